// File: rtl/aes_stream_ctrl.sv
// Sequencing controller in front of the AES core: applies keys, streams
// plaintext blocks one at a time, and returns ciphertext with a round-trip check.
module aes_stream_ctrl #(
  parameter int KEYX_LAT = 10,
  parameter int CORE_LAT = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [127:0] core_key,
  output logic [127:0] core_plain,
  input  logic [127:0] core_cipher,
  input  logic [127:0] core_decrypted,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err,
  output logic         err_sticky,
  output logic         key_valid,
  output logic [15:0]  blk_count
);

  typedef enum logic [1:0] {IDLE, KEYX, WAIT, OUT} state_t;

  localparam logic [15:0] KEYX_CNT = 16'(KEYX_LAT);
  localparam logic [15:0] CORE_CNT = 16'(CORE_LAT);

  state_t       state;
  logic [15:0]  cnt;
  logic         key_pend;
  logic [127:0] key_shadow;
  logic [127:0] ref_plain;
  logic         mismatch;

  // The only combinational output: a key request in the same cycle blocks acceptance.
  assign in_ready = (state == IDLE) && key_valid && !key_pend && !key_load;
  assign mismatch = (core_decrypted != ref_plain);

  // NOTE: every register below is written with <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      key_pend   <= 1'b0;
      key_shadow <= '0;
      ref_plain  <= '0;
      core_key   <= '0;
      core_plain <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
      key_valid  <= 1'b0;
      blk_count  <= '0;
    end else begin
      // Keys requested while busy are parked; the last request wins.
      if (key_load && state != IDLE) begin
        key_pend   <= 1'b1;
        key_shadow <= key_in;
      end

      case (state)
        IDLE: begin
          if (key_load) begin
            core_key   <= key_in;
            err_sticky <= 1'b0;
            key_pend   <= 1'b0;
            cnt        <= KEYX_CNT;
            state      <= KEYX;
          end else if (key_pend) begin
            core_key   <= key_shadow;
            err_sticky <= 1'b0;
            key_pend   <= 1'b0;
            cnt        <= KEYX_CNT;
            state      <= KEYX;
          end else if (in_valid && in_ready) begin
            core_plain <= in_data;
            ref_plain  <= in_data;
            cnt        <= CORE_CNT;
            state      <= WAIT;
          end
        end

        KEYX: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            key_valid <= 1'b1;
            state     <= IDLE;
          end
        end

        WAIT: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            out_data   <= core_cipher;
            out_err    <= mismatch;
            err_sticky <= err_sticky | mismatch;
            out_valid  <= 1'b1;
            state      <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + 16'd1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with an XOR core stub whose results
// settle CORE_LAT cycles after core_plain changes.
module tb_aes_stream_ctrl;

  localparam int KEYX_LAT = 10;
  localparam int CORE_LAT = 11;

  localparam logic [127:0] KEY  = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] KA   = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
  localparam logic [127:0] KB   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] B1   = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
  localparam logic [127:0] B1_C = 128'h10F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0;
  localparam logic [127:0] B2   = 128'h0123456789ABCDEF0011223344556677;
  localparam logic [127:0] B3   = 128'hDEADBEEFCAFEF00D1234567890ABCDEF;
  localparam logic [127:0] B4   = 128'h11111111222222223333333344444444;
  localparam logic [127:0] B5   = 128'hFFFFFFFF00000000FFFFFFFF00000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] core_key;
  logic [127:0] core_plain;
  logic [127:0] core_cipher;
  logic [127:0] core_decrypted;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         err_sticky;
  logic         key_valid;
  logic [15:0]  blk_count;
  logic         corrupt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.KEYX_LAT(KEYX_LAT), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_key(core_key), .core_plain(core_plain),
    .core_cipher(core_cipher), .core_decrypted(core_decrypted),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_sticky(err_sticky), .key_valid(key_valid),
    .blk_count(blk_count)
  );

  // Core stub: a combinational XOR feeding CORE_LAT-1 registers, so a value
  // presented at edge N is sampled correctly by the controller at edge N+CORE_LAT.
  logic [127:0] c_pipe [CORE_LAT-1];
  logic [127:0] d_pipe [CORE_LAT-1];
  always @(posedge clk) begin
    c_pipe[0] <= core_plain ^ core_key;
    d_pipe[0] <= (core_plain ^ core_key) ^ core_key;
    for (int i = 1; i < CORE_LAT - 1; i++) begin
      c_pipe[i] <= c_pipe[i-1];
      d_pipe[i] <= d_pipe[i-1];
    end
  end
  assign core_cipher    = c_pipe[CORE_LAT-2];
  assign core_decrypted = d_pipe[CORE_LAT-2] ^ {127'b0, corrupt};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a block and returns right after the accepting edge.
  task automatic send(input logic [127:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    if (!out_valid) check("out_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) check("ready_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int bad;
    rst = 1'b0; key_in = '0; key_load = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1; corrupt = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_blk_count", blk_count, 16'h0);
    check("rst_in_ready", in_ready, 1'b0);
    step(); step();
    #2 rst = 1'b1;

    // Block offered with no key loaded is refused.
    in_valid = 1'b1; in_data = B1;
    bad = 0;
    repeat (3) begin step(); if (in_ready) bad++; end
    check("rdy_nokey", bad, 0);

    key_load = 1'b1; key_in = KEY;
    #1 check("rdy_keyload", in_ready, 1'b0);
    step();
    key_load = 1'b0;
    check("core_key_applied", core_key, KEY);
    repeat (KEYX_LAT - 1) step();
    check("kv_early", key_valid, 1'b0);
    step();
    check("kv_set", key_valid, 1'b1);
    check("rdy_after_keyx", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("core_plain_b1", core_plain, B1);
    check("rdy_wait", in_ready, 1'b0);
    repeat (CORE_LAT - 1) step();
    check("ov_early", out_valid, 1'b0);
    step();
    check("ov_b1", out_valid, 1'b1);
    check("out_data_b1", out_data, B1_C);
    check("out_err_b1", out_err, 1'b0);
    step();
    check("ov_cleared", out_valid, 1'b0);
    check("blk_count_1", blk_count, 16'd1);
    check("rdy_after_hs", in_ready, 1'b1);

    // Back-pressure: result held, nothing else accepted.
    out_ready = 1'b0;
    send(B2);
    wait_out(lat);
    check("lat_b2", lat, CORE_LAT);
    bad = 0;
    in_valid = 1'b1; in_data = B5;
    repeat (20) begin
      step();
      if (!out_valid || out_data !== (B2 ^ KEY) || in_ready) bad++;
    end
    check("hold_stable", bad, 0);
    check("core_plain_held", core_plain, B2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("ov_release", out_valid, 1'b0);
    check("blk_count_2", blk_count, 16'd2);
    repeat (3) step();
    check("blk_count_once", blk_count, 16'd2);

    // key_load and in_valid together in IDLE: key wins, block taken after KEYX.
    in_valid = 1'b1; in_data = B5; key_load = 1'b1; key_in = KEY;
    #1 check("rdy_keyload_vs_valid", in_ready, 1'b0);
    step();
    key_load = 1'b0;
    check("core_plain_not_taken", core_plain, B2);
    wait_ready(n);
    check("keyx_lat", n, KEYX_LAT);
    step();
    in_valid = 1'b0;
    check("core_plain_b5", core_plain, B5);
    wait_out(lat);
    check("out_data_b5", out_data, B5 ^ KEY);
    step();

    // Corrupted round-trip on one block only.
    corrupt = 1'b1;
    send(B4);
    wait_out(lat);
    check("out_err_bad", out_err, 1'b1);
    check("sticky_set", err_sticky, 1'b1);
    check("out_data_b4", out_data, B4 ^ KEY);
    corrupt = 1'b0;
    step();
    send(B3);
    wait_out(lat);
    check("out_err_good", out_err, 1'b0);
    check("sticky_hold", err_sticky, 1'b1);
    step();

    // Two key pulses during WAIT: block finishes on old key, KB applied after.
    send(B2);
    repeat (3) step();
    key_load = 1'b1; key_in = KA;
    step();
    key_in = KB;
    step();
    key_load = 1'b0;
    wait_out(lat);
    check("out_data_oldkey", out_data, B2 ^ KEY);
    check("core_key_old", core_key, KEY);
    step();
    check("rdy_pend", in_ready, 1'b0);
    step();
    check("core_key_kb", core_key, KB);
    check("sticky_cleared", err_sticky, 1'b0);
    wait_ready(n);
    check("keyx_lat_pend", n, KEYX_LAT);
    send(B1);
    wait_out(lat);
    check("out_data_kb", out_data, B1 ^ KB);
    step();
    check("blk_count_7", blk_count, 16'd7);

    // Reset mid-WAIT aborts the block.
    send(B2);
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_data", out_data, 128'h0);
    check("mrst_core_plain", core_plain, 128'h0);
    check("mrst_core_key", core_key, 128'h0);
    check("mrst_key_valid", key_valid, 1'b0);
    check("mrst_blk_count", blk_count, 16'h0);
    check("mrst_in_ready", in_ready, 1'b0);
    #2 rst = 1'b1;
    bad = 0;
    repeat (15) begin step(); if (out_valid || in_ready) bad++; end
    check("post_rst_quiet", bad, 0);

    // Counter wrap from 0xFFFF.
    key_load = 1'b1; key_in = KEY;
    step();
    key_load = 1'b0;
    force dut.blk_count = 16'hFFFF;
    step();
    release dut.blk_count;
    step();
    check("blk_count_preload", blk_count, 16'hFFFF);
    send(B5);
    wait_out(lat);
    step();
    check("blk_count_wrap", blk_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Sequencing controller placed in front of the AES core (`AES_top`). It accepts a 128-bit key and a stream of 128-bit plaintext blocks over valid/ready handshakes. It drives the core's `key` and `plain_text` inputs, waits the core's fixed settling latency, and returns the `cipher_text` result over a valid/ready output. It also checks that the core's `decrypted_plain_text` round-trip matches the original block, and keeps a completion count and a sticky error flag.

## Interface
- `KEYX_LAT`, default 10: cycles allowed for key expansion after a new key is applied (minimum 1).
- `CORE_LAT`, default 11: cycles from a new `core_plain` until `core_cipher`/`core_decrypted` are valid (minimum 1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key_in`  in  128  key to apply.
- `key_load`  in  1  one-cycle key load request.
- `in_valid`  in  1  plaintext block valid.
- `in_ready`  out  1  controller can accept a block.
- `in_data`  in  128  plaintext block.
- `core_key`  out  128  registered, drives the core `key`.
- `core_plain`  out  128  registered, drives the core `plain_text`.
- `core_cipher`  in  128  from the core `cipher_text`.
- `core_decrypted`  in  128  from the core `decrypted_plain_text`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  128  captured ciphertext.
- `out_err`  out  1  round-trip mismatch for the current `out_data`.
- `err_sticky`  out  1  set by any mismatch; cleared on an accepted `key_load`.
- `key_valid`  out  1  a key has been fully expanded since reset.
- `blk_count`  out  16  number of completed output handshakes.

## Operation
- States: IDLE, KEYX, WAIT, OUT.
- Reset (`rst`=0) clears all outputs and registers to zero and puts the FSM in IDLE.
  - Reset mid-operation aborts the block in flight. No output is produced for it.
  - A key must be reloaded after reset.
- IDLE with `key_load`=1:
  - Register `key_in` into `core_key` and clear `err_sticky`.
  - Load the counter with `KEYX_LAT` and go to KEYX.
  - `key_load` has priority over `in_valid` in the same cycle. `in_ready` is low whenever `key_load` is high.
- `key_load` arriving in KEYX, WAIT or OUT:
  - Set `key_pend` and latch `key_in` into a shadow register. A later pulse overwrites the shadow (last wins).
  - On return to IDLE, the pending key is applied exactly as a fresh `key_load`, before any further block is accepted.
- KEYX:
  - Decrement the counter each cycle.
  - When it reaches 0, set `key_valid`=1 and go to IDLE.
- `in_ready` = (state==IDLE) & `key_valid` & !`key_pend` & !`key_load`.
- Accept a block on `in_valid` & `in_ready`:
  - `core_plain` <= `in_data`, and the block is also saved as the reference copy.
  - Load the counter with `CORE_LAT` and go to WAIT.
- WAIT:
  - Decrement the counter.
  - When it reaches 0, capture `out_data` <= `core_cipher` and `out_err` <= (`core_decrypted` != reference copy).
  - OR `out_err` into `err_sticky`, set `out_valid`=1 and go to OUT.
- OUT:
  - `out_data` and `out_err` are held stable while `out_valid` & !`out_ready`.
  - On `out_valid` & `out_ready`: clear `out_valid`, increment `blk_count` (mod 2^16, 0xFFFF wraps to 0x0000) and go to IDLE.
- `core_key` changes only on leaving IDLE to enter KEYX. `core_plain` changes only on block acceptance.
- Only one block is in flight at any time.

## Timing
- Key applied at edge K: `key_valid` rises (or stays 1) and IDLE is re-entered after edge K+`KEYX_LAT`. `in_ready` can be high in the cycle that follows.
- Block accepted at edge N: `out_valid`=1 after edge N+`CORE_LAT`.
- Output handshake at edge M: `in_ready`=1 in the cycle after M, provided no key is pending.
- Sustained throughput with `out_ready` held at 1: one block per `CORE_LAT`+2 cycles.
- The output stage is registered. There is no combinational path from `in_valid` or `out_ready` to any output except `in_ready`, which depends on `key_load`.
- `in_ready` is never high during KEYX, WAIT or OUT, even if `out_ready` is high.

## Test plan
- Defaults; bench core stub where cipher = plain^key and decrypted = cipher^key, registered through `CORE_LAT` stages. Key 0x100F0E0D0C0B0A090807060504030201, then block 0x00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1 with `out_ready`=1 -> `out_valid` exactly 11 cycles after accept, `out_data` = block^key, `out_err`=0, `blk_count`=1.
- Block offered before any key, or `in_valid` together with `key_load` in IDLE -> `in_ready`=0. The key is expanded first and the block is accepted 10 cycles later.
- `out_ready`=0 for 20 cycles -> `out_data` held stable and `in_ready` low throughout. Release -> exactly one handshake and `blk_count` increments by 1.
- `key_load` pulsed twice (keys A then B) during WAIT -> the current block completes under the old key. KEYX then runs with key B only, and `err_sticky` is cleared.
- Stub corrupts bit 0 of `decrypted` for one block -> `out_err`=1 for that block only, and `err_sticky`=1 until the next `key_load`.
- `rst` asserted mid-WAIT -> all outputs 0 immediately and `key_valid`=0. Separately: preload `blk_count`=0xFFFF by forced count, then one more block -> 0x0000.
